// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types for the instruction fetch controller: queue entry layout,
// fetch FSM states and fixed instruction geometry.
package instr_fetch_ctrl_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    RUN,
    FAULT_PEND,
    HALT
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Bundle of the redirect, ROM request/response and decode handshake signals.
// Suffixes are relative to the fetch controller (master side).
interface instr_fetch_ctrl_if;
  import instr_fetch_ctrl_pkg::*;

  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            mem_req_o;
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;
  logic            instr_valid_o;
  logic [XLEN-1:0] instr_o;
  logic [XLEN-1:0] instr_pc_o;
  logic            instr_fault_o;
  logic            instr_ready_i;

  modport master (
    input  redirect_i, redirect_pc_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, instr_ready_i,
    output mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o, instr_fault_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, instr_ready_i,
    input  mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o, instr_fault_o
  );

endinterface

// File: rtl/instr_fetch_ctrl_sync_fifo.sv
// Synchronous FIFO of arbitrary element type with a flush that empties it in one cycle.
// Push into a full FIFO is only honoured together with a pop; pop from empty is ignored.
module instr_fetch_ctrl_sync_fifo #(
  parameter type         T     = logic [31:0],
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  T                 data_i,
  input  logic             pop_i,
  output T                 data_o,
  output logic [CNT_W-1:0] count_o
);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             doPush, doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign doPop   = pop_i && (count_q != '0);
  assign doPush  = push_i && ((count_q != CNT_W'(DEPTH)) || doPop);
  assign data_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= nextPtr(wrPtr_q);
      if (doPop)  rdPtr_q <= nextPtr(rdPtr_q);
      if (doPush && !doPop)      count_q <= count_q + CNT_W'(1);
      else if (!doPush && doPop) count_q <= count_q - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries are only observed while the count says they are valid.
  always_ff @(posedge clk_i) begin
    if (doPush && !flush_i) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: issues word reads from the boot ROM, queues responses for decode,
// drops responses made stale by a redirect and turns out-of-window fetches into fault entries.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH      = XLEN,
  parameter logic [DATA_WIDTH-1:0] RESET_PC        = 32'hBFC0_0000,
  parameter logic [DATA_WIDTH-1:0] ROM_FIRST       = 32'hBFC0_0000,
  parameter logic [DATA_WIDTH-1:0] ROM_LAST        = 32'hBFC0_0FFF,
  parameter int unsigned           FIFO_DEPTH      = 4,
  parameter int unsigned           MAX_OUTSTANDING = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  instr_fetch_ctrl_if.master bus
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] fetchPc_q, fetchPc_d;
  logic [OUT_W-1:0]      drop_q, drop_d;

  logic [OUT_W-1:0]      tagCount;
  logic [DATA_WIDTH-1:0] tagPc;
  logic [CNT_W-1:0]      pfCount;
  fetch_entry_t          pfHead, pfPushData;

  logic inRange, slotFree, underMax, pfNotFull;
  logic memReq, issue, respPush, faultPush, pfPush, pfPop, headValid;

  assign inRange   = (fetchPc_q >= ROM_FIRST) &&
                     (fetchPc_q <= ROM_LAST - DATA_WIDTH'(INSTR_BYTES - 1));
  // Requests reserve a queue slot up front, so a response can never find the queue full.
  assign slotFree  = (32'(pfCount) + 32'(tagCount)) < 32'(FIFO_DEPTH);
  assign underMax  = 32'(tagCount) < MAX_OUTSTANDING;
  assign pfNotFull = 32'(pfCount) < FIFO_DEPTH;

  assign memReq    = rst_ni && (state_q == RUN) && inRange && slotFree && underMax &&
                     !bus.redirect_i;
  assign issue     = memReq && bus.mem_gnt_i;
  assign respPush  = bus.mem_rvalid_i && !bus.redirect_i && (drop_q == '0);
  assign faultPush = (state_q == FAULT_PEND) && (tagCount == '0) && pfNotFull &&
                     !bus.redirect_i;
  assign pfPush    = respPush || faultPush;
  assign headValid = (pfCount != '0);
  assign pfPop     = headValid && bus.instr_ready_i && !bus.redirect_i;

  always_comb begin
    pfPushData = '0;
    if (faultPush) begin
      pfPushData.pc    = fetchPc_q;
      pfPushData.fault = 1'b1;
    end else begin
      pfPushData.instr = bus.mem_rdata_i;
      pfPushData.pc    = tagPc;
    end
  end

  // The tag queue doubles as the outstanding-request counter; it is never flushed
  // so that dropped responses still retire their tags in order.
  instr_fetch_ctrl_sync_fifo #(
    .T     (logic [DATA_WIDTH-1:0]),
    .DEPTH (MAX_OUTSTANDING)
  ) tagQueue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .push_i  (issue),
    .data_i  (fetchPc_q),
    .pop_i   (bus.mem_rvalid_i),
    .data_o  (tagPc),
    .count_o (tagCount)
  );

  instr_fetch_ctrl_sync_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (FIFO_DEPTH)
  ) prefetchQueue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (bus.redirect_i),
    .push_i  (pfPush),
    .data_i  (pfPushData),
    .pop_i   (pfPop),
    .data_o  (pfHead),
    .count_o (pfCount)
  );

  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    drop_d    = drop_q;
    if (issue) fetchPc_d = fetchPc_q + DATA_WIDTH'(INSTR_BYTES);
    if (bus.mem_rvalid_i && (drop_q != '0)) drop_d = drop_q - OUT_W'(1);
    case (state_q)
      RUN:        if (!inRange) state_d = FAULT_PEND;
      FAULT_PEND: if (faultPush) state_d = HALT;
      default:    state_d = state_q;
    endcase
    // Redirect wins: everything still in flight after this cycle becomes stale.
    if (bus.redirect_i) begin
      state_d   = RUN;
      fetchPc_d = bus.redirect_pc_i & ~DATA_WIDTH'(3);
      drop_d    = tagCount - OUT_W'(bus.mem_rvalid_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      fetchPc_q <= RESET_PC;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      fetchPc_q <= fetchPc_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.mem_req_o     = memReq;
  assign bus.mem_addr_o    = memReq ? fetchPc_q : '0;
  assign bus.instr_valid_o = headValid;
  assign bus.instr_o       = headValid ? pfHead.instr : '0;
  assign bus.instr_pc_o    = headValid ? pfHead.pc : '0;
  assign bus.instr_fault_o = headValid && pfHead.fault;

  rvalidNeedsOutstanding : assert property (
    @(posedge clk_i) disable iff (!rst_ni) bus.mem_rvalid_i |-> (tagCount != '0)
  );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: a vector table for streaming and backpressure,
// plus hand-written sequences for redirect, fault, grant stall and mid-run reset.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] BASE = 32'hBFC0_0000;

  typedef struct {
    logic        ready;
    logic        expValid;
    logic [31:0] expPc;
    logic        expReq;
    logic [31:0] expAddr;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          delay;
  } pend_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  int    latency = 1;
  int    testsRun = 0;
  int    testsFailed = 0;
  pend_t pend[$];
  vec_t  tbl[$];

  instr_fetch_ctrl_if bus ();

  instr_fetch_ctrl dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] romWord(input logic [31:0] addr);
    return addr ^ 32'hA5A5_5A5A;
  endfunction

  function automatic vec_t mk(input logic rdy, input logic v, input logic [31:0] pcOff,
                              input logic rq, input logic [31:0] addrOff);
    vec_t e;
    e.ready    = rdy;
    e.expValid = v;
    e.expPc    = v ? BASE + pcOff : 32'h0;
    e.expReq   = rq;
    e.expAddr  = rq ? BASE + addrOff : 32'h0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives inputs at the falling edge (releasing any held reset) and settles before checks.
  task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] rpc,
                               input logic gnt);
    @(negedge clk);
    rst_n             = 1'b1;
    bus.instr_ready_i = rdy;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = rpc;
    bus.mem_gnt_i     = gnt;
    #2;
  endtask

  task automatic doReset();
    rst_n             = 1'b0;
    bus.instr_ready_i = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.mem_gnt_i     = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " req"},   bus.mem_req_o,     0);
    checkOutput({tag, " addr"},  bus.mem_addr_o,    0);
    checkOutput({tag, " valid"}, bus.instr_valid_o, 0);
    checkOutput({tag, " instr"}, bus.instr_o,       0);
    checkOutput({tag, " pc"},    bus.instr_pc_o,    0);
    checkOutput({tag, " fault"}, bus.instr_fault_o, 0);
  endtask

  // In-order ROM model: a response returns `latency` cycles after its grant.
  initial begin
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = '0;
      if (!rst_n) pend.delete();
      else if (pend.size() > 0) begin
        if (pend[0].delay == 0) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = romWord(pend[0].addr);
          void'(pend.pop_front());
        end
        foreach (pend[i]) if (pend[i].delay > 0) pend[i].delay = pend[i].delay - 1;
      end
      #1;
      if (rst_n && bus.mem_req_o && bus.mem_gnt_i)
        pend.push_back('{addr: bus.mem_addr_o, delay: latency - 1});
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", testsRun);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic found;
    int   reqSeen;

    // Streaming with ready=1, then 10 cycles of backpressure, then release.
    tbl.push_back(mk(1, 0, 'h00, 1, 'h00));
    tbl.push_back(mk(1, 0, 'h00, 1, 'h04));
    tbl.push_back(mk(1, 1, 'h00, 1, 'h08));
    tbl.push_back(mk(1, 1, 'h04, 1, 'h0C));
    tbl.push_back(mk(1, 1, 'h08, 1, 'h10));
    tbl.push_back(mk(1, 1, 'h0C, 1, 'h14));
    tbl.push_back(mk(1, 1, 'h10, 1, 'h18));
    tbl.push_back(mk(1, 1, 'h14, 1, 'h1C));
    tbl.push_back(mk(0, 1, 'h18, 1, 'h20));
    tbl.push_back(mk(0, 1, 'h18, 1, 'h24));
    for (int k = 10; k < 18; k++) tbl.push_back(mk(0, 1, 'h18, 0, 'h00));
    tbl.push_back(mk(1, 1, 'h18, 0, 'h00));
    tbl.push_back(mk(1, 1, 'h1C, 1, 'h28));
    tbl.push_back(mk(1, 1, 'h20, 1, 'h2C));
    tbl.push_back(mk(1, 1, 'h24, 1, 'h30));
    tbl.push_back(mk(1, 1, 'h28, 1, 'h34));
    tbl.push_back(mk(1, 1, 'h2C, 1, 'h38));

    doReset();
    checkIdle("reset");

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].ready, 1'b0, '0, 1'b1);
      checkOutput($sformatf("vec%0d valid", i), bus.instr_valid_o, tbl[i].expValid);
      checkOutput($sformatf("vec%0d pc", i), bus.instr_pc_o, tbl[i].expPc);
      checkOutput($sformatf("vec%0d instr", i), bus.instr_o,
                  tbl[i].expValid ? romWord(tbl[i].expPc) : 32'h0);
      checkOutput($sformatf("vec%0d fault", i), bus.instr_fault_o, 0);
      checkOutput($sformatf("vec%0d req", i), bus.mem_req_o, tbl[i].expReq);
      checkOutput($sformatf("vec%0d addr", i), bus.mem_addr_o, tbl[i].expAddr);
    end

    // Redirect with two requests in flight: both responses must be dropped.
    doReset();
    latency = 3;
    applyStimulus(0, 0, '0, 1);
    applyStimulus(0, 0, '0, 1);
    applyStimulus(0, 1, 32'hBFC0_0103, 1);
    checkOutput("t3 req in redirect", bus.mem_req_o, 0);
    applyStimulus(0, 0, '0, 1);
    checkOutput("t3 req while draining", bus.mem_req_o, 0);
    checkOutput("t3 valid after flush", bus.instr_valid_o, 0);
    applyStimulus(0, 0, '0, 1);
    checkOutput("t3 req restart", bus.mem_req_o, 1);
    checkOutput("t3 addr restart", bus.mem_addr_o, 32'hBFC0_0100);
    found = 1'b0;
    for (int n = 0; n < 12 && !found; n++) begin
      applyStimulus(0, 0, '0, 1);
      found = bus.instr_valid_o;
    end
    checkOutput("t3 valid seen", found, 1);
    checkOutput("t3 first pc", bus.instr_pc_o, 32'hBFC0_0100);
    checkOutput("t3 first instr", bus.instr_o, romWord(32'hBFC0_0100));

    // Last ROM word, then a fault entry for the address just past the window.
    doReset();
    latency = 1;
    applyStimulus(0, 1, 32'hBFC0_0FFC, 1);
    checkOutput("t4 req in redirect", bus.mem_req_o, 0);
    applyStimulus(0, 0, '0, 1);
    checkOutput("t4 req last", bus.mem_req_o, 1);
    checkOutput("t4 addr last", bus.mem_addr_o, 32'hBFC0_0FFC);
    applyStimulus(0, 0, '0, 1);
    checkOutput("t4 req past end", bus.mem_req_o, 0);
    applyStimulus(0, 0, '0, 1);
    checkOutput("t4 valid last", bus.instr_valid_o, 1);
    checkOutput("t4 pc last", bus.instr_pc_o, 32'hBFC0_0FFC);
    checkOutput("t4 instr last", bus.instr_o, romWord(32'hBFC0_0FFC));
    checkOutput("t4 fault last", bus.instr_fault_o, 0);
    applyStimulus(1, 0, '0, 1);
    checkOutput("t4 head held", bus.instr_pc_o, 32'hBFC0_0FFC);
    applyStimulus(1, 0, '0, 1);
    checkOutput("t4 fault valid", bus.instr_valid_o, 1);
    checkOutput("t4 fault pc", bus.instr_pc_o, 32'hBFC0_1000);
    checkOutput("t4 fault flag", bus.instr_fault_o, 1);
    checkOutput("t4 fault instr", bus.instr_o, 0);
    reqSeen = 0;
    for (int n = 0; n < 7; n++) begin
      applyStimulus(0, 0, '0, 1);
      if (bus.mem_req_o) reqSeen++;
    end
    checkOutput("t4 req cycles in halt", reqSeen, 0);
    checkOutput("t4 valid after fault", bus.instr_valid_o, 0);

    // Grant stall: address holds, a redirect replaces it and its grant is not counted.
    applyStimulus(0, 1, 32'hBFC0_0200, 0);
    checkOutput("t5 req in redirect", bus.mem_req_o, 0);
    for (int n = 0; n < 5; n++) begin
      applyStimulus(0, 0, '0, 0);
      checkOutput($sformatf("t5 stall%0d req", n), bus.mem_req_o, 1);
      checkOutput($sformatf("t5 stall%0d addr", n), bus.mem_addr_o, 32'hBFC0_0200);
    end
    applyStimulus(0, 1, 32'hBFC0_0300, 1);
    checkOutput("t5 req in redirect 2", bus.mem_req_o, 0);
    applyStimulus(1, 0, '0, 1);
    checkOutput("t5 new addr", bus.mem_addr_o, 32'hBFC0_0300);
    applyStimulus(1, 0, '0, 1);
    checkOutput("t5 next addr", bus.mem_addr_o, 32'hBFC0_0304);
    applyStimulus(1, 0, '0, 1);
    checkOutput("t5 first valid", bus.instr_valid_o, 1);
    checkOutput("t5 first pc", bus.instr_pc_o, 32'hBFC0_0300);
    checkOutput("t5 first instr", bus.instr_o, romWord(32'hBFC0_0300));

    // Reset with one entry queued and two requests outstanding.
    doReset();
    latency = 1;
    applyStimulus(0, 0, '0, 1);
    latency = 3;
    applyStimulus(0, 0, '0, 1);
    applyStimulus(0, 0, '0, 1);
    applyStimulus(0, 0, '0, 1);
    checkOutput("t6 entry queued", bus.instr_pc_o, BASE);
    checkOutput("t6 req blocked", bus.mem_req_o, 0);
    #1;
    rst_n = 1'b0;
    #1;
    checkIdle("t6 async reset");
    latency = 1;
    repeat (2) @(negedge clk);
    applyStimulus(1, 0, '0, 1);
    checkOutput("t6 req after release", bus.mem_req_o, 1);
    checkOutput("t6 addr after release", bus.mem_addr_o, BASE);
    applyStimulus(1, 0, '0, 1);
    checkOutput("t6 no early valid", bus.instr_valid_o, 0);
    applyStimulus(1, 0, '0, 1);
    checkOutput("t6 valid", bus.instr_valid_o, 1);
    checkOutput("t6 pc", bus.instr_pc_o, BASE);
    checkOutput("t6 instr", bus.instr_o, romWord(BASE));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
